hazard_stall_controller: RTL
============================

# hazard_stall_controller

Central stall/flush sequencer for the 5-stage pipelined MIPS core. Decides each cycle whether the program counter and the pipeline registers advance, hold or flush. Sources: load-use hazards, decode-stage branch dependencies, taken branches/jumps, and instruction/data memory wait handshakes. A wait-timeout FSM and a saturating stall counter support debug.

## Interface
Parameters:
- TIMEOUT, 255, max consecutive memory-wait cycles before fault
- CNT_W, 32, width of stall performance counter

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low
- rs_d, rt_d  in  5  source registers of instruction in Decode
- branch_d  in  1  Decode holds a conditional branch
- pcsrc_d  in  1  branch resolved taken in Decode
- jump_d  in  1  Decode holds j/jal
- rt_e, writereg_e  in  5  Execute rt field / destination register
- memtoreg_e, regwrite_e  in  1  Execute is a load / writes a register
- writereg_m  in  5  Memory-stage destination register
- memtoreg_m  in  1  Memory stage is a load
- imem_req, imem_ready  in  1  fetch request / instruction memory ready
- dmem_req_m, dmem_ready  in  1  data access in Memory stage / data memory ready
- stall_f  out  1  hold PC; drives PC enable (PC loads only while low)
- stall_d, stall_e, stall_m  out  1  hold the IF/ID, ID/EX, EX/MEM registers
- flush_d, flush_e  out  1  clear IF/ID, ID/EX to a bubble
- mem_timeout  out  1  sticky fault flag
- stall_count  out  CNT_W  cycles with stall_f=1, saturating

## Operation
- Register 0 never creates a hazard; every compare is gated with reg!=0.
- Load-use: memtoreg_e && rt_e∈{rs_d,rt_d} → stall_f=stall_d=1, flush_e=1.
- Branch dependency: branch_d && ((regwrite_e && writereg_e∈{rs_d,rt_d}) || (memtoreg_m && writereg_m∈{rs_d,rt_d})) → stall_f=stall_d=1, flush_e=1.
- Redirect: (pcsrc_d||jump_d) and no hazard stall this cycle → flush_d=1.
- Data wait: dmem_req_m && !dmem_ready → stall_f, stall_d, stall_e and stall_m all 1. All flushes forced 0.
- Instruction wait: imem_req && !imem_ready, no data wait → stall_f=stall_d=1, flush_e=1. flush_d forced 0; redirect is deferred until the fetch completes.
- Priority: FAULT > data wait > instruction wait > load-use/branch stall > redirect flush.
- FSM states: RUN, IWAIT, DWAIT, FAULT.
  - RUN→DWAIT on data wait; RUN→IWAIT on instruction wait.
  - IWAIT/DWAIT→RUN when the corresponding ready is seen; IWAIT→DWAIT if a data wait arises.
  - Any wait state→FAULT when wait_cnt reaches TIMEOUT.
  - FAULT is left only by reset; all four stalls held at 1, flushes 0, mem_timeout=1.
- wait_cnt: width $clog2(TIMEOUT+1). Cleared in RUN and on any wait-kind change; +1 per cycle in IWAIT/DWAIT.
- stall_count: +1 on each cycle with stall_f=1; holds at 2^CNT_W-1.

## Timing
- Hazard and wait outputs are Mealy: combinational from the current inputs and state, zero-cycle latency. The PC and pipeline registers act on them at the same edge.
- Load-use stall lasts exactly one cycle; on the next edge the load moves to Memory and the condition clears.
- A ready asserted in the same cycle as req causes no stall and no state change.
- Reset (async assert) values: state=RUN, wait_cnt=0, stall_count=0, mem_timeout=0.
- While reset is low, all stall/flush outputs are 0. Reset mid-wait or in FAULT returns to RUN immediately; no pending stall survives.
- Fault is entered at the edge where wait_cnt==TIMEOUT. With TIMEOUT=255, that is the 256th consecutive wait cycle; mem_timeout is visible from the following cycle.

## Structure
- Shared package mips_pkg: state enum (RUN, IWAIT, DWAIT, FAULT), REG_ZERO=5'd0, register-index width 5.
- One sub-module hazard_detect: purely combinational load-use/branch compare, instantiated once. The FSM, counters and priority mux stay in the top.

## Test plan
- Load-use: memtoreg_e=1, rt_e=8, rs_d=8 → one cycle stall_f=stall_d=flush_e=1, then all 0. Repeat with rt_e=0 → no stall.
- Branch dependency: branch_d=1, regwrite_e=1, writereg_e=9, rt_d=9 → stall+flush_e. Next cycle memtoreg_m=1, writereg_m=9 → second stall cycle.
- Taken branch: pcsrc_d=1, no hazards → flush_d=1 single cycle, stall_f=0. Same with a load-use hazard present → stall wins, flush_d=0.
- Data wait: dmem_req_m=1, dmem_ready low 3 cycles → stall_f/d/e/m=1 for 3 cycles, state DWAIT, stall_count=3, back to RUN when ready.
- Timeout: TIMEOUT=4, imem_ready held low → FAULT after 5 wait cycles, mem_timeout=1 sticky. Async reset low mid-cycle → all outputs 0, state RUN.
- Counter saturation: CNT_W=4, 20 stall cycles → stall_count=15.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control logic.
//   REG_W / REG_ZERO : register-index width and the hard-wired zero register
//   ctrl_state_t     : stall sequencer states (RUN, IWAIT, DWAIT, FAULT)
//   reg_match        : true when a destination register feeds a source,
//                      never for register 0 (writes to $zero are discarded)
package mips_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2,
        FAULT = 2'd3
    } ctrl_state_t;

    function automatic logic reg_match(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_hazard_detect.sv
// hazard_detect: purely combinational data-hazard compare for Decode.
//   i_rs_d, i_rt_d          : Decode source registers
//   i_branch_d              : Decode holds a conditional branch
//   i_rt_e, i_writereg_e    : Execute rt field / destination
//   i_memtoreg_e            : Execute is a load
//   i_regwrite_e            : Execute writes a register
//   i_writereg_m            : Memory-stage destination
//   i_memtoreg_m            : Memory stage is a load
//   o_lwstall               : load-use hazard
//   o_branchstall           : branch operand not yet available in Decode
module hazard_detect
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] i_rs_d,
    input  logic [REG_W-1:0] i_rt_d,
    input  logic             i_branch_d,
    input  logic [REG_W-1:0] i_rt_e,
    input  logic [REG_W-1:0] i_writereg_e,
    input  logic             i_memtoreg_e,
    input  logic             i_regwrite_e,
    input  logic [REG_W-1:0] i_writereg_m,
    input  logic             i_memtoreg_m,
    output logic             o_lwstall,
    output logic             o_branchstall
);

    logic [REG_W-1:0] w_src [2];
    logic [1:0]       w_lu_hit;
    logic [1:0]       w_ex_hit;
    logic [1:0]       w_mem_hit;

    assign w_src[0] = i_rs_d;
    assign w_src[1] = i_rt_d;

    // One compare set per Decode source operand.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign w_lu_hit[gi]  = reg_match(i_rt_e, w_src[gi]);
            assign w_ex_hit[gi]  = reg_match(i_writereg_e, w_src[gi]);
            assign w_mem_hit[gi] = reg_match(i_writereg_m, w_src[gi]);
        end
    endgenerate

    assign o_lwstall     = i_memtoreg_e && (|w_lu_hit);
    // Branches compare in Decode, so an ALU result still in Execute or a
    // load still in Memory cannot be forwarded in time.
    assign o_branchstall = i_branch_d &&
                           ((i_regwrite_e && (|w_ex_hit)) ||
                            (i_memtoreg_m && (|w_mem_hit)));

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: per-cycle advance/hold/flush decision for the
// 5-stage MIPS pipeline, plus memory-wait timeout FSM and stall counter.
//   clk, reset (async, active-low)
//   rs_d, rt_d, branch_d, pcsrc_d, jump_d   : Decode-stage info
//   rt_e, writereg_e, memtoreg_e, regwrite_e: Execute-stage info
//   writereg_m, memtoreg_m                  : Memory-stage info
//   imem_req/imem_ready, dmem_req_m/dmem_ready : memory handshakes
//   stall_f/d/e/m, flush_d/e                : pipeline control (Mealy)
//   mem_timeout                             : sticky wait-timeout fault
//   stall_count                             : saturating stall_f cycle count
module hazard_stall_controller
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic             branch_d,
    input  logic             pcsrc_d,
    input  logic             jump_d,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic             memtoreg_e,
    input  logic             regwrite_e,
    input  logic [REG_W-1:0] writereg_m,
    input  logic             memtoreg_m,
    input  logic             imem_req,
    input  logic             imem_ready,
    input  logic             dmem_req_m,
    input  logic             dmem_ready,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(TIMEOUT + 1);
    // Fault is taken on the edge at which the count would reach TIMEOUT.
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    ctrl_state_t      r_state;
    ctrl_state_t      w_state_next;
    logic [WC_W-1:0]  r_wait_cnt;
    logic [WC_W-1:0]  w_wait_cnt_next;
    logic             r_mem_timeout;
    logic [CNT_W-1:0] r_stall_count;

    logic w_lwstall;
    logic w_branchstall;
    logic w_iwait;
    logic w_dwait;

    hazard_detect u_hazard_detect (
        .i_rs_d        (rs_d),
        .i_rt_d        (rt_d),
        .i_branch_d    (branch_d),
        .i_rt_e        (rt_e),
        .i_writereg_e  (writereg_e),
        .i_memtoreg_e  (memtoreg_e),
        .i_regwrite_e  (regwrite_e),
        .i_writereg_m  (writereg_m),
        .i_memtoreg_m  (memtoreg_m),
        .o_lwstall     (w_lwstall),
        .o_branchstall (w_branchstall)
    );

    assign w_dwait = dmem_req_m && !dmem_ready;
    assign w_iwait = imem_req && !imem_ready;

    // Next state and wait counter. The counter restarts whenever the wait
    // kind changes and only advances while the same wait persists.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = '0;
        unique case (r_state)
            RUN: begin
                if (w_dwait)      w_state_next = DWAIT;
                else if (w_iwait) w_state_next = IWAIT;
            end
            IWAIT: begin
                if (w_dwait) begin
                    w_state_next = DWAIT;
                end else if (!w_iwait) begin
                    w_state_next = RUN;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                    if (r_wait_cnt == WC_LAST) w_state_next = FAULT;
                end
            end
            DWAIT: begin
                if (!w_dwait) begin
                    w_state_next = RUN;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                    if (r_wait_cnt == WC_LAST) w_state_next = FAULT;
                end
            end
            FAULT: begin
                w_wait_cnt_next = r_wait_cnt;
            end
        endcase
    end

    // Priority mux: FAULT > data wait > instruction wait > hazard > redirect.
    // Everything is held inactive while reset is asserted.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (reset) begin
            if (r_state == FAULT || w_dwait) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else if (w_iwait || w_lwstall || w_branchstall) begin
                // A pending redirect is dropped here and re-presented by
                // Decode once the front end can advance again.
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end else if (pcsrc_d || jump_d) begin
                flush_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_state_next == FAULT) r_mem_timeout <= 1'b1;
            if (stall_f && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_count = r_stall_count;

endmodule
